// File: rtl/cla_serial_adder_if.sv
// Handshake and operand/result bundle for cla_serial_adder.
// The master drives a request (start/op/a/b/ci) and observes the result
// (s/co/busy/done). The slave is the adder itself.
// With CLA_SERIAL_OVF_EN defined, the bundle also carries the signed
// overflow flag ovf.
interface cla_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             busy;
  logic             done;
`ifdef CLA_SERIAL_OVF_EN
  logic             ovf;

  modport master (
    output start, op, a, b, ci,
    input  s, co, busy, done, ovf
  );

  modport slave (
    input  start, op, a, b, ci,
    output s, co, busy, done, ovf
  );
`else
  modport master (
    output start, op, a, b, ci,
    input  s, co, busy, done
  );

  modport slave (
    input  start, op, a, b, ci,
    output s, co, busy, done
  );
`endif
endinterface

// File: rtl/cla_serial_adder.sv
// cla_serial_adder: wide add/subtract built from a single 4-bit
// carry-lookahead slice. Operands are latched on start, then processed
// one nibble per clock, LSB first, with the slice carry fed back. The
// result and carry are published together on the last nibble, and done
// pulses for one cycle.
// Optional feature: define CLA_SERIAL_OVF_EN to add the registered
// signed-overflow output ovf.

// 4-bit carry-lookahead slice: generate/propagate with fully expanded
// carries, so each nibble step is a single slice delay.
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o  = p ^ c[3:0];
  assign co_o = c[4];
endmodule

module cla_serial_adder #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset_n,
  cla_serial_adder_if.slave bus
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             load;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_s;
  logic             slice_co;

`ifdef CLA_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_a = opa_q[4*k +: 4];
        nib_b = opb_q[4*k +: 4];
      end
    end
  end

  cla4 u_slice (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  // Sequencer: accepts requests in IDLE/DONE, steps nibbles in RUN and
  // publishes the full result on the last step.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    partial_d = partial_q;
    s_d       = s_q;
    co_d      = co_q;
    load      = 1'b0;
`ifdef CLA_SERIAL_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1, so the incoming ci is replaced.
          load    = 1'b1;
          carry_d = bus.op ? 1'b1 : bus.ci;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int k = 0; k < N; k++) begin
          if (idx_q == IDX_W'(k)) begin
            partial_d[4*k +: 4] = slice_s;
          end
        end
        carry_d = slice_co;
        if (idx_q == LAST_IDX) begin
          s_d     = partial_d;
          co_d    = slice_co;
`ifdef CLA_SERIAL_OVF_EN
          // opb_q is already inverted for subtract, so one formula covers both.
          ovf_d   = (opa_q[WIDTH-1] ~^ opb_q[WIDTH-1])
                  & (partial_d[WIDTH-1] ^ opa_q[WIDTH-1]);
`endif
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control, working and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      partial_q <= '0;
      s_q       <= '0;
      co_q      <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      partial_q <= partial_d;
      s_q       <= s_d;
      co_q      <= co_d;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Operand latches; B is stored pre-inverted for subtract.
  always_ff @(posedge clk) begin
    if (load) begin
      opa_q <= bus.a;
      opb_q <= bus.b ^ {WIDTH{bus.op}};
    end
  end

  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
`ifdef CLA_SERIAL_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder (WIDTH=32 main instance plus a
// WIDTH=4 instance for the single-nibble case). Expected results are
// queued when a request is driven and popped when done is observed.
// Overflow checks are active when CLA_SERIAL_OVF_EN is defined.
module tb_cla_serial_adder;
  localparam int N32 = 8;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  exp_t sb[$];

  cla_serial_adder_if #(.WIDTH(32)) bus32 ();
  cla_serial_adder_if #(.WIDTH(4))  bus4 ();

  cla_serial_adder #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus32)
  );

  cla_serial_adder #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow = true sum not representable.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic op, input logic ci);
    exp_t        r;
    logic [32:0] u;
    longint      sa, sbv, sr;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!op) begin
      u    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      r.s  = u[31:0];
      r.co = u[32];
      sr   = sa + sbv + longint'(ci);
    end else begin
      r.s  = a - b;
      r.co = (a >= b);
      sr   = sa - sbv;
    end
    r.ovf = (sr != longint'($signed(r.s)));
    return r;
  endfunction

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check32({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check32({tag, "_s"}, bus32.s, e.s);
      check1({tag, "_co"}, bus32.co, e.co);
`ifdef CLA_SERIAL_OVF_EN
      check1({tag, "_ovf"}, bus32.ovf, e.ovf);
`endif
    end
  endtask

  // One request on the 32-bit instance; optionally pulses start mid-run.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic ci, input exp_t e, input int ignore_at);
    int k;
    int busy_cnt;
    @(negedge clk);
    bus32.a = a; bus32.b = b; bus32.op = op; bus32.ci = ci; bus32.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus32.start = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (bus32.done !== 1'b1 && k < N32 + 4) begin
      if (bus32.busy === 1'b1) busy_cnt++;
      if (k == ignore_at) begin
        bus32.start = 1'b1;
        bus32.a = 32'hDEAD_BEEF; bus32.b = 32'h0BAD_F00D; bus32.op = ~op;
      end else begin
        bus32.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    check32({tag, "_latency"}, 32'(k), 32'(N32));
    check32({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N32));
    check1({tag, "_busy_at_done"}, bus32.busy, 1'b0);
    pop_compare(tag);
    @(negedge clk);
    check1({tag, "_done_one_cycle"}, bus32.done, 1'b0);
  endtask

  initial begin
    int   k;
    int   m;
    int   done_seen;
    exp_t e;
    logic [31:0] ra, rb;
    logic        rop, rci;

    total = 0;
    bad   = 0;

    // Reset with arbitrary inputs, checked before any clock edge.
    reset_n = 1'b1;
    bus32.start = 1'b1; bus32.op = 1'b1; bus32.ci = 1'b1;
    bus32.a = 32'hA5A5_1234; bus32.b = 32'h5A5A_9876;
    bus4.start = 1'b1; bus4.op = 1'b0; bus4.ci = 1'b1; bus4.a = 4'h9; bus4.b = 4'h6;
    #2 reset_n = 1'b0;
    #1;
    check32("reset_s", bus32.s, 32'h0);
    check1("reset_co", bus32.co, 1'b0);
    check1("reset_busy", bus32.busy, 1'b0);
    check1("reset_done", bus32.done, 1'b0);
`ifdef CLA_SERIAL_OVF_EN
    check1("reset_ovf", bus32.ovf, 1'b0);
`endif
    bus32.start = 1'b0;
    bus4.start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed add/subtract/overflow cases.
    do_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}, -1);
    do_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}, -1);
    do_op("sub_7_5", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, '{32'h0000_0002, 1'b1, 1'b0}, -1);
    do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}, -1);
    do_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1}, -1);
    do_op("add_ci", 32'h0000_000F, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0010, 1'b0, 1'b0}, -1);

    // start pulsed with other operands mid-run must not disturb the result.
    do_op("ignore", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, '{32'h0000_0030, 1'b0, 1'b0}, 3);

    // Abort by reset mid-operation: outputs clear at once, no done afterwards.
    @(negedge clk);
    bus32.a = 32'h0101_0101; bus32.b = 32'h0202_0202; bus32.op = 1'b0; bus32.ci = 1'b0;
    bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check1("abort_busy", bus32.busy, 1'b0);
    check1("abort_done", bus32.done, 1'b0);
    check32("abort_s", bus32.s, 32'h0);
    check1("abort_co", bus32.co, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus32.done === 1'b1) done_seen++;
    end
    check32("abort_no_done", 32'(done_seen), 32'd0);

    // Back-to-back: start held high through the DONE cycle.
    @(negedge clk);
    bus32.a = 32'h0000_0001; bus32.b = 32'h0000_0002; bus32.op = 1'b0; bus32.ci = 1'b0;
    bus32.start = 1'b1;
    sb.push_back('{32'h0000_0003, 1'b0, 1'b0});
    @(negedge clk);
    k = 0;
    while (bus32.done !== 1'b1 && k < N32 + 4) begin
      @(negedge clk);
      k++;
    end
    check32("b2b_first_latency", 32'(k), 32'(N32));
    pop_compare("b2b_first");
    bus32.a = 32'h1234_5678; bus32.b = 32'h1111_1111;
    sb.push_back('{32'h2345_6789, 1'b0, 1'b0});
    @(negedge clk);
    bus32.start = 1'b0;
    m = 1;
    check1("b2b_rerun_busy", bus32.busy, 1'b1);
    check32("b2b_hold_early", bus32.s, 32'h0000_0003);
    while (bus32.done !== 1'b1 && m < N32 + 6) begin
      if (m == N32) check32("b2b_hold_late", bus32.s, 32'h0000_0003);
      @(negedge clk);
      m++;
    end
    check32("b2b_second_gap", 32'(m), 32'(N32 + 1));
    pop_compare("b2b_second");

    // A few random requests against the integer model.
    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      e   = model(ra, rb, rop, rci);
      do_op("rand", ra, rb, rop, rci, e, -1);
    end
    e = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op("add_all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, e, -1);
    e = model(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    do_op("sub_zero", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, e, -1);

    // Single-nibble instance: one-cycle latency.
    @(negedge clk);
    bus4.a = 4'hF; bus4.b = 4'h1; bus4.op = 1'b0; bus4.ci = 1'b0; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    check1("w4_busy", bus4.busy, 1'b1);
    check1("w4_done_early", bus4.done, 1'b0);
    @(negedge clk);
    check1("w4_done", bus4.done, 1'b1);
    check32("w4_s", 32'(bus4.s), 32'h0);
    check1("w4_co", bus4.co, 1'b1);
`ifdef CLA_SERIAL_OVF_EN
    check1("w4_ovf", bus4.ovf, 1'b0);
`endif

    check32("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_serial_adder.md
# cla_serial_adder

Sequential multi-word adder/subtractor built around one `cla4` slice. It latches two WIDTH-bit operands and feeds the slice one nibble per clock, LSB first, threading the slice's carry-out back as the next nibble's carry-in. It consumes the slice's sum and carry outputs and presents a registered WIDTH-bit result with a start/done handshake. It sits directly upstream and downstream of `cla4`: the operand sequencer and result collector for wide additions on small hardware.

## Interface
- `WIDTH`, 32: operand width in bits; must be a multiple of 4, minimum 4. N = WIDTH/4 nibble steps.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `op`  in  1  0 = add, 1 = subtract (a − b)
- `a`  in  WIDTH  operand A, sampled with `start`
- `b`  in  WIDTH  operand B, sampled with `start`
- `ci`  in  1  carry-in for add; ignored when op=1
- `s`  out  WIDTH  result, registered
- `co`  out  1  carry-out of MSB nibble, registered
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle completion pulse
- `ovf`  out  1  signed overflow; present only with CLA_SERIAL_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1: latch `a` into opA and `b ^ {WIDTH{op}}` into opB. Carry register = `op ? 1 : ci`. Nibble index = 0. Go to RUN.
- Working nibbles are loaded into an internal partial-sum register. `s` and `co` are untouched during RUN.
- RUN, each edge:
  - Drive `cla4` with opA[4i+3:4i], opB[4i+3:4i] and the carry register.
  - Store the slice sum into partial[4i+3:4i]. Store the slice `co` into the carry register.
  - i = N−1: copy the full partial result to `s` and the final carry to `co`, then go to DONE. Otherwise i = i+1.
- DONE: `done`=1 for exactly one cycle.
  - `start`=1: accepted as above, go to RUN.
  - Otherwise: go to IDLE.
- `s`/`co` hold the last result until the next completion.
- `start` during RUN is ignored; the operation in flight is unaffected.
- Subtract: `co`=1 means no borrow (a ≥ b unsigned).
- Index counter width is ceil(log2 N), min 1. It never wraps past N−1.
- Reset, including mid-operation: state IDLE, partial and carry cleared, `s`=0, `co`=0, `busy`=0, `done`=0, `ovf`=0. An aborted operation never produces `done`.

## Timing
- `start` sampled at edge E0. Nibble k is processed at edge E(k+1).
- Edge EN writes `s`/`co` and enters DONE. `done` is high from EN to EN+1.
- Latency from the start edge to visible `done`/result is N cycles: 8 for WIDTH=32, 1 for WIDTH=4.
- `busy` is high from E0 to EN, i.e. N cycles.
- Back-to-back: `start` held high in the DONE cycle re-enters RUN at EN+1. Throughput is one result per N+1 cycles.
- Only combinational path: the `cla4` slice, between operand/carry registers and the partial/carry registers. No input-to-output combinational path.

## Configuration
- `CLA_SERIAL_OVF_EN` defined:
  - The `ovf` port exists.
  - Registered with `s` at edge EN as (opA[MSB] ~^ opB[MSB]) & (s_new[MSB] ^ opA[MSB]). opB is the already-inverted operand.
  - Cleared by reset. Held until the next completion.
- Not defined: no `ovf` port and no overflow logic.

## Test plan
- Reset: assert `reset_n`=0 with arbitrary inputs → `s`=0, `co`=0, `busy`=0, `done`=0 (and `ovf`=0) immediately, without a clock edge.
- Add, WIDTH=32, a=0x0000_0001, b=0xFFFF_FFFF, ci=0 → `s`=0x0000_0000, `co`=1. `done` is high exactly 8 cycles after the start edge; `busy` is high for 8 cycles.
- Subtract, a=0x0000_0005, b=0x0000_0007, ci=1 (must be ignored) → `s`=0xFFFF_FFFE, `co`=0, `ovf`=0. Repeat with a=7, b=5 → `s`=0x0000_0002, `co`=1.
- Overflow (macro on): a=0x7FFF_FFFF, b=0x0000_0001, add, ci=0 → `s`=0x8000_0000, `co`=0, `ovf`=1. Then a=0x8000_0000, b=1, subtract → `s`=0x7FFF_FFFF, `co`=1, `ovf`=1.
- Abort and ignore: start an add, then pulse `start` with new operands at cycle 3 → ignored, original result delivered. Next op: drop `reset_n` at cycle 4 → `busy`=0, no `done`, `s`=0.
- Back-to-back: hold `start` high through the DONE cycle with a=0x1234_5678, b=0x1111_1111 → the second result 0x2345_6789 (`co`=0) arrives N+1 cycles after the first `done`. The first result is held until then.
